// File: rtl/hazard3_ahb_excl_monitor.sv
// Global AHB5 exclusive monitor: one reservation per hart, hexokay generation, failed-SC suppression.
// Latency: address path is combinational (zero added latency); reservations update at data-phase end.
// Backpressure: s_hready follows m_hready, except a locally completed failed SC which is always ready.
module hazard3_ahb_excl_monitor #(
  parameter int W_ADDR  = 32,
  parameter int W_DATA  = 32,
  parameter int N_HARTS = 2
) (
  input  logic              clk,
  input  logic              rst,
  // upstream (from the hart interconnect)
  input  logic [W_ADDR-1:0] s_haddr,
  input  logic              s_hwrite,
  input  logic [1:0]        s_htrans,
  input  logic [2:0]        s_hsize,
  input  logic [7:0]        s_hmaster,
  input  logic              s_hexcl,
  input  logic [W_DATA-1:0] s_hwdata,
  output logic              s_hready,
  output logic              s_hresp,
  output logic              s_hexokay,
  output logic [W_DATA-1:0] s_hrdata,
  // downstream (towards the shared memory)
  output logic [W_ADDR-1:0] m_haddr,
  output logic              m_hwrite,
  output logic [1:0]        m_htrans,
  output logic [2:0]        m_hsize,
  output logic [W_DATA-1:0] m_hwdata,
  input  logic              m_hready,
  input  logic              m_hresp,
  input  logic [W_DATA-1:0] m_hrdata
);

  localparam int         W_HART      = (N_HARTS > 1) ? $clog2(N_HARTS) : 1;
  localparam int         W_WORD      = W_ADDR - 2;
  localparam logic [7:0] N_HARTS_ID  = 8'(N_HARTS);
  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  // Data-phase register: describes the transfer whose data phase is in progress.
  logic              dp_active_q, dp_active_d;
  logic              dp_excl_q,   dp_excl_d;
  logic              dp_write_q,  dp_write_d;
  logic              dp_fail_q,   dp_fail_d;
  logic [W_HART-1:0] dp_hart_q,   dp_hart_d;
  logic [W_WORD-1:0] dp_word_q,   dp_word_d;

  // Reservation slots, one per hart, at word granularity.
  logic [N_HARTS-1:0]             res_vld_q,  res_vld_d;
  logic [N_HARTS-1:0][W_WORD-1:0] res_addr_q, res_addr_d;

  // Address-phase decode.
  logic              addr_excl;
  logic [W_HART-1:0] addr_hart;
  logic [W_WORD-1:0] addr_word;
  logic              addr_sc_pass;
  logic              addr_fail;

  // Data-phase status.
  logic dp_local;
  logic dp_done;

  // Only harts can hold reservations; the debugger (and any other master) is plain.
  assign addr_excl = s_hexcl && (s_hmaster < N_HARTS_ID);
  assign addr_hart = s_hmaster[W_HART-1:0];
  assign addr_word = s_haddr[W_ADDR-1:2];

  // A failed SC is served by this block itself: always ready, never an error.
  assign dp_local = dp_active_q && dp_fail_q;
  assign dp_done  = dp_active_q && s_hready;

  assign s_hready  = dp_local ? 1'b1 : m_hready;
  assign s_hresp   = dp_local ? 1'b0 : m_hresp;
  assign s_hrdata  = m_hrdata;
  // Exclusive success needs a forwarded exclusive transfer completing with OKAY.
  assign s_hexokay = dp_active_q && dp_excl_q && !dp_fail_q && m_hready && !m_hresp;

  // Reservation next state: applied only at the edge that ends a data phase.
  always_comb begin
    res_vld_d  = res_vld_q;
    res_addr_d = res_addr_q;
    if (dp_done) begin
      if (dp_fail_q) begin
        res_vld_d[dp_hart_q] = 1'b0;
      end else if (dp_excl_q && !dp_write_q) begin
        if (!m_hresp) begin
          res_vld_d[dp_hart_q]  = 1'b1;
          res_addr_d[dp_hart_q] = dp_word_q;
        end else begin
          res_vld_d[dp_hart_q] = 1'b0;
        end
      end else if (dp_write_q && !m_hresp) begin
        // Any successful store (plain or SC) kills every reservation on that word.
        for (int i = 0; i < N_HARTS; i++) begin
          if (res_addr_q[i] == dp_word_q) begin
            res_vld_d[i] = 1'b0;
          end
        end
      end
    end
  end

  // The SC check looks at the post-update reservations so a store finishing this cycle wins.
  assign addr_sc_pass = res_vld_d[addr_hart] && (res_addr_d[addr_hart] == addr_word);
  assign addr_fail    = s_htrans[1] && addr_excl && s_hwrite && !addr_sc_pass;

  assign m_haddr  = s_haddr;
  assign m_hwrite = s_hwrite;
  assign m_hsize  = s_hsize;
  assign m_hwdata = s_hwdata;
  assign m_htrans = addr_fail ? HTRANS_IDLE : s_htrans;

  // Data-phase capture: loads on every upstream-ready cycle, holds through wait states.
  always_comb begin
    dp_active_d = dp_active_q;
    dp_excl_d   = dp_excl_q;
    dp_write_d  = dp_write_q;
    dp_fail_d   = dp_fail_q;
    dp_hart_d   = dp_hart_q;
    dp_word_d   = dp_word_q;
    if (s_hready) begin
      dp_active_d = s_htrans[1];
      dp_excl_d   = addr_excl;
      dp_write_d  = s_hwrite;
      dp_fail_d   = addr_fail;
      dp_hart_d   = addr_hart;
      dp_word_d   = addr_word;
    end
  end

  // Data-phase register state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp_active_q <= 1'b0;
      dp_excl_q   <= 1'b0;
      dp_write_q  <= 1'b0;
      dp_fail_q   <= 1'b0;
      dp_hart_q   <= '0;
      dp_word_q   <= '0;
    end else begin
      dp_active_q <= dp_active_d;
      dp_excl_q   <= dp_excl_d;
      dp_write_q  <= dp_write_d;
      dp_fail_q   <= dp_fail_d;
      dp_hart_q   <= dp_hart_d;
      dp_word_q   <= dp_word_d;
    end
  end

  // Reservation slot state; reset drops every reservation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_vld_q  <= '0;
      res_addr_q <= '0;
    end else begin
      res_vld_q  <= res_vld_d;
      res_addr_q <= res_addr_d;
    end
  end

`ifndef SYNTHESIS
  // A local SC failure must look like a clean single-cycle OKAY without exclusive success.
  a_local_clean: assert property (@(posedge clk) disable iff (rst)
    dp_local |-> (s_hready && !s_hresp && !s_hexokay));
  // Exclusive-okay is only meaningful in the last cycle of a data phase.
  a_exokay_dp: assert property (@(posedge clk) disable iff (rst)
    s_hexokay |-> (dp_active_q && s_hready));
`endif

endmodule

// File: tb/tb_hazard3_ahb_excl_monitor.sv
// Bench for hazard3_ahb_excl_monitor: upstream AHB master driver, downstream memory slave,
// transaction-level reservation model feeding expectation queues, and an independent monitor.
// Directed scenarios first, then randomized traffic, then a mid-wait-state reset.
module tb_hazard3_ahb_excl_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] s_haddr;
  logic        s_hwrite;
  logic [1:0]  s_htrans;
  logic [2:0]  s_hsize;
  logic [7:0]  s_hmaster;
  logic        s_hexcl;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic        s_hresp;
  logic        s_hexokay;
  logic [31:0] s_hrdata;
  logic [31:0] m_haddr;
  logic        m_hwrite;
  logic [1:0]  m_htrans;
  logic [2:0]  m_hsize;
  logic [31:0] m_hwdata;
  logic        m_hready;
  logic        m_hresp;
  logic [31:0] m_hrdata;

  logic        sl_hready, sl_hresp;
  logic [31:0] sl_hrdata;

  always #5 clk = ~clk;

  // The slave has its own asynchronous reset: ready/OKAY while rst is high.
  assign m_hready = rst ? 1'b1 : sl_hready;
  assign m_hresp  = rst ? 1'b0 : sl_hresp;
  assign m_hrdata = sl_hrdata;

  hazard3_ahb_excl_monitor #(.W_ADDR(32), .W_DATA(32), .N_HARTS(2)) dut (
    .clk(clk), .rst(rst),
    .s_haddr(s_haddr), .s_hwrite(s_hwrite), .s_htrans(s_htrans), .s_hsize(s_hsize),
    .s_hmaster(s_hmaster), .s_hexcl(s_hexcl), .s_hwdata(s_hwdata),
    .s_hready(s_hready), .s_hresp(s_hresp), .s_hexokay(s_hexokay), .s_hrdata(s_hrdata),
    .m_haddr(m_haddr), .m_hwrite(m_hwrite), .m_htrans(m_htrans), .m_hsize(m_hsize),
    .m_hwdata(m_hwdata), .m_hready(m_hready), .m_hresp(m_hresp), .m_hrdata(m_hrdata)
  );

  typedef struct { bit exokay; bit err; bit chk_rd; logic [31:0] rdata; } dexp_t;
  typedef struct { bit fwd; logic [31:0] addr; } aexp_t;
  typedef struct { int waits; bit err; } plan_t;

  aexp_t aexp_q[$];
  dexp_t dexp_q[$];
  plan_t plan_q[$];

  int total = 0;
  int bad   = 0;

  logic [31:0] mem_s [256];
  logic [31:0] mem_m [256];
  bit          rm_vld  [2];
  logic [29:0] rm_word [2];

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] addr,
                                        input logic [2:0] size, input logic [31:0] wd);
    logic [31:0] r;
    bit hit;
    r = old;
    for (int b = 0; b < 4; b++) begin
      case (size)
        3'd0:    hit = (b == int'(addr[1:0]));
        3'd1:    hit = ((b / 2) == int'(addr[1]));
        default: hit = 1'b1;
      endcase
      if (hit) r[b*8 +: 8] = wd[b*8 +: 8];
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model at transaction level, then drive the address phase until accepted.
  task automatic issue(input logic [7:0] mst, input bit excl, input bit wr, input logic [31:0] addr,
                       input logic [2:0] size, input logic [31:0] wd, input int waits, input bit err);
    bit          cap, fwd;
    int          h, n;
    logic [29:0] word;
    dexp_t       e;
    aexp_t       a;
    plan_t       p;
    cap  = excl && (mst < 8'd2);
    h    = int'(mst[0]);
    word = addr[31:2];
    fwd  = !(cap && wr && !(rm_vld[h] && rm_word[h] == word));
    e.exokay = 1'b0; e.err = 1'b0; e.chk_rd = 1'b0; e.rdata = '0;
    if (!fwd) begin
      rm_vld[h] = 1'b0;
    end else begin
      p.waits = waits; p.err = err;
      plan_q.push_back(p);
      e.err = err;
      if (err) begin
        if (cap && !wr) rm_vld[h] = 1'b0;
      end else begin
        e.exokay = cap;
        if (wr) begin
          mem_m[addr[9:2]] = merge(mem_m[addr[9:2]], addr, size, wd);
          for (int i = 0; i < 2; i++) if (rm_word[i] == word) rm_vld[i] = 1'b0;
        end else begin
          e.chk_rd = 1'b1;
          e.rdata  = mem_m[addr[9:2]];
          if (cap) begin
            rm_vld[h]  = 1'b1;
            rm_word[h] = word;
          end
        end
      end
    end
    a.fwd = fwd; a.addr = addr;
    aexp_q.push_back(a);
    dexp_q.push_back(e);
    s_haddr = addr; s_hwrite = wr; s_hsize = size; s_hmaster = mst; s_hexcl = excl;
    s_htrans = 2'b10;
    n = 0;
    while (1) begin
      @(negedge clk);
      if (s_hready) break;
      n++;
      if (n > 200) begin
        total++; bad++;
        $display("FAIL accept_timeout: got hready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
    @(posedge clk); #1;
    s_hwdata = wd;
    s_htrans = 2'b00;
    s_hexcl  = 1'b0;
  endtask

  task automatic idle(input int n);
    s_htrans = 2'b00;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (dexp_q.size() != 0 && n < 300) begin @(posedge clk); #1; n++; end
    total++;
    if (dexp_q.size() != 0) begin
      bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", dexp_q.size());
    end
  endtask

  // Monitor: pops expectations whenever the DUT completes an address or data phase.
  initial begin : monitor
    bit    in_dp;
    dexp_t e;
    aexp_t a;
    in_dp = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_dp = 1'b0;
      end else begin
        if (in_dp && s_hready) begin
          if (dexp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_data_phase: got completion expected none at %0t", $time);
          end else begin
            e = dexp_q.pop_front();
            check1("exokay", s_hexokay, e.exokay);
            check1("hresp", s_hresp, e.err);
            if (e.chk_rd) check("rdata", s_hrdata, e.rdata);
          end
          in_dp = 1'b0;
        end else begin
          check1("exokay_quiet", s_hexokay, 1'b0);
        end
        if (s_htrans[1] && s_hready) begin
          if (aexp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_addr_phase: got transfer expected none at %0t", $time);
          end else begin
            a = aexp_q.pop_front();
            check("m_htrans", 32'(m_htrans), a.fwd ? 32'd2 : 32'd0);
            check("m_haddr", m_haddr, a.addr);
          end
          in_dp = 1'b1;
        end
      end
    end
  end

  // Downstream memory slave with planned wait states and two-cycle error responses.
  initial begin : slave
    logic [1:0]  smp_trans;
    logic [31:0] smp_addr, smp_wd;
    logic        smp_wr, smp_rdy;
    logic [2:0]  smp_size;
    bit          sl_act, sl_wr, sl_err, sl_estage;
    logic [31:0] sl_addr;
    logic [2:0]  sl_size;
    int          sl_waits;
    plan_t       p;
    sl_hready = 1'b1; sl_hresp = 1'b0; sl_hrdata = '0;
    sl_act = 1'b0; sl_wr = 1'b0; sl_err = 1'b0; sl_estage = 1'b0;
    sl_addr = '0; sl_size = '0; sl_waits = 0;
    forever begin
      @(negedge clk);
      smp_trans = m_htrans; smp_addr = m_haddr; smp_wr = m_hwrite;
      smp_size = m_hsize; smp_wd = m_hwdata; smp_rdy = m_hready;
      @(posedge clk); #1;
      if (rst) begin
        sl_act = 1'b0; sl_hready = 1'b1; sl_hresp = 1'b0;
      end else begin
        if (sl_act && smp_rdy) begin
          if (sl_wr && !sl_err) mem_s[sl_addr[9:2]] = merge(mem_s[sl_addr[9:2]], sl_addr, sl_size, smp_wd);
          sl_act = 1'b0;
        end
        if (smp_rdy && smp_trans[1]) begin
          sl_act = 1'b1; sl_addr = smp_addr; sl_wr = smp_wr; sl_size = smp_size;
          if (plan_q.size() != 0) p = plan_q.pop_front();
          else begin p.waits = 0; p.err = 1'b0; end
          sl_waits = p.waits; sl_err = p.err; sl_estage = 1'b0;
        end
        if (sl_act) begin
          if (sl_waits > 0) begin
            sl_hready = 1'b0; sl_hresp = 1'b0; sl_waits--;
          end else if (sl_err && !sl_estage) begin
            sl_hready = 1'b0; sl_hresp = 1'b1; sl_estage = 1'b1;
          end else begin
            sl_hready = 1'b1; sl_hresp = sl_err;
            sl_hrdata = sl_wr ? 32'h0 : mem_s[sl_addr[9:2]];
          end
        end else begin
          sl_hready = 1'b1; sl_hresp = 1'b0;
        end
      end
    end
  end

  initial begin : stim
    logic [7:0]  mst;
    bit          excl, wr, err;
    logic [31:0] addr, wd;
    logic [2:0]  size;
    rst = 1'b1;
    s_haddr = '0; s_hwrite = 1'b0; s_htrans = 2'b00; s_hsize = 3'd2;
    s_hmaster = '0; s_hexcl = 1'b0; s_hwdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem_s[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      mem_m[i] = (i * 32'h01010101) ^ 32'hA5A50000;
    end
    for (int i = 0; i < 2; i++) begin rm_vld[i] = 1'b0; rm_word[i] = '0; end
    #12;
    check1("rst_hready", s_hready, 1'b1);
    check1("rst_hresp", s_hresp, 1'b0);
    check1("rst_exokay", s_hexokay, 1'b0);
    check("rst_m_htrans", 32'(m_htrans), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // LR/SC success, then a second SC sees the cleared slot, then read back.
    issue(8'h00, 1, 0, 32'h100, 3'd2, 32'h0, 0, 0);
    issue(8'h00, 1, 1, 32'h100, 3'd2, 32'h0000CAFE, 1, 0);
    idle(2);
    issue(8'h00, 1, 1, 32'h100, 3'd2, 32'h11111111, 0, 0);
    issue(8'h00, 0, 0, 32'h100, 3'd2, 32'h0, 0, 0);
    // SC without LR, memory unchanged.
    issue(8'h01, 1, 1, 32'h200, 3'd2, 32'hDEADBEEF, 0, 0);
    issue(8'h01, 0, 0, 32'h200, 3'd2, 32'h0, 0, 0);
    // Intervening byte store by the other hart.
    issue(8'h00, 1, 0, 32'h100, 3'd2, 32'h0, 0, 0);
    issue(8'h01, 0, 1, 32'h103, 3'd0, 32'h77777777, 1, 0);
    issue(8'h00, 1, 1, 32'h100, 3'd2, 32'h22222222, 0, 0);
    // Store data phase with two waits ends in the same cycle as the SC address phase.
    issue(8'h00, 1, 0, 32'h100, 3'd2, 32'h0, 0, 0);
    idle(1);
    issue(8'h01, 0, 1, 32'h100, 3'd2, 32'h00000055, 2, 0);
    issue(8'h00, 1, 1, 32'h100, 3'd2, 32'h33333333, 0, 0);
    // Debugger exclusive store acts as a plain store.
    issue(8'h00, 1, 0, 32'h100, 3'd2, 32'h0, 0, 0);
    idle(1);
    issue(8'h10, 1, 1, 32'h100, 3'd2, 32'h00000099, 0, 0);
    issue(8'h00, 1, 1, 32'h100, 3'd2, 32'h44444444, 0, 0);
    // LR with error response, then SC fails.
    issue(8'h00, 1, 0, 32'h300, 3'd2, 32'h0, 0, 1);
    issue(8'h00, 1, 1, 32'h300, 3'd2, 32'h55555555, 0, 0);
    idle(2);
    drain();

    // Randomized traffic over a few contended words.
    for (int it = 0; it < 500; it++) begin
      case ($urandom_range(0, 3))
        0: mst = 8'h00;
        1: mst = 8'h01;
        2: mst = 8'h10;
        default: mst = 8'h02;
      endcase
      excl = ($urandom_range(0, 1) == 1);
      wr   = ($urandom_range(0, 1) == 1);
      addr = 32'h100 + 32'(4 * $urandom_range(0, 3));
      size = 3'd2;
      if (wr && !excl && $urandom_range(0, 3) == 0) begin
        size = 3'd0;
        addr = addr + 32'($urandom_range(0, 3));
      end
      wd  = $urandom;
      err = ($urandom_range(0, 9) == 0);
      issue(mst, excl, wr, addr, size, wd, int'($urandom_range(0, 2)), err);
      if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
    end
    idle(2);
    drain();

    // Reset in the middle of a wait state loses the reservation.
    issue(8'h00, 1, 0, 32'h180, 3'd2, 32'h0, 0, 0);
    idle(3);
    issue(8'h01, 0, 0, 32'h1C0, 3'd2, 32'h0, 6, 0);
    idle(2);
    #1;
    rst = 1'b1;
    aexp_q.delete(); dexp_q.delete(); plan_q.delete();
    for (int i = 0; i < 2; i++) rm_vld[i] = 1'b0;
    #1;
    check1("midrst_hready", s_hready, 1'b1);
    check1("midrst_hresp", s_hresp, 1'b0);
    check1("midrst_exokay", s_hexokay, 1'b0);
    check("midrst_m_htrans", 32'(m_htrans), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;
    issue(8'h00, 1, 1, 32'h180, 3'd2, 32'h66666666, 0, 0);
    issue(8'h00, 0, 0, 32'h180, 3'd2, 32'h0, 0, 0);
    idle(2);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard3_ahb_excl_monitor.md
# hazard3_ahb_excl_monitor

Global exclusive-access monitor between the hart AHB5 master ports (after the multi-hart interconnect) and a shared memory slave. It tracks one reservation per hart, identified by `hmaster`, and produces `hexokay` for exclusive transfers. Failed exclusive writes are suppressed toward the slave and completed locally. Plain transfers pass through with zero added latency.

## Interface
- `W_ADDR`, 32, address width
- `W_DATA`, 32, data width
- `N_HARTS`, 2, number of reservation slots; hart index = `s_hmaster[$clog2(N_HARTS)-1:0]`, valid only when `s_hmaster < N_HARTS`

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; one clock, reset is asynchronous and active-high
- `s_haddr`  in  W_ADDR  upstream address
- `s_hwrite`  in  1  upstream write
- `s_htrans`  in  2  upstream transfer type
- `s_hsize`  in  3  upstream size
- `s_hmaster`  in  8  upstream master ID (hart ID; 0x10 = debug SBA)
- `s_hexcl`  in  1  upstream exclusive flag
- `s_hwdata`  in  W_DATA  upstream write data
- `s_hready`  out  1  upstream ready
- `s_hresp`  out  1  upstream error response
- `s_hexokay`  out  1  upstream exclusive-okay
- `s_hrdata`  out  W_DATA  upstream read data
- `m_haddr`, `m_hwrite`, `m_hsize`, `m_hwdata`  out  W_ADDR/1/3/W_DATA  downstream, equal to the corresponding `s_*` inputs
- `m_htrans`  out  2  downstream transfer type; equals `s_htrans`, or IDLE when suppressed
- `m_hready`  in  1  downstream ready
- `m_hresp`  in  1  downstream error response
- `m_hrdata`  in  W_DATA  downstream read data

## Operation
- Reservation state per slot: `res_vld` and `res_addr[W_ADDR-1:2]`. Match granule is a 4-byte word, compared on `haddr[W_ADDR-1:2]`.
- Address phase accepted when `s_htrans[1] && s_hready`. The data-phase register captures: active, excl, write, hart, word address, and local_fail.
- Exclusive-capable: `s_hexcl && s_hmaster < N_HARTS`. Any other transfer is treated as plain; `hexcl` from the debugger (0x10) is ignored.
- Exclusive read: passes downstream. On OKAY completion, set own slot to {1, word}, replacing any previous reservation. On error, clear own slot. `s_hexokay`=1 in the final data-phase cycle if OKAY.
- Exclusive write success: own slot valid and word equal. Passes downstream. `s_hexokay`=1 on completion. On OKAY completion, clear every slot (own included) whose word matches.
- Exclusive write fail: `m_htrans` forced to IDLE in that address phase. The data phase is served locally: `s_hready`=1, `s_hresp`=0, `s_hexokay`=0, 1 cycle. Own slot is cleared.
- Plain write (any master) completing OKAY: clear all slots whose word matches. Plain reads have no effect on reservations.
- The success check uses forwarded state: if a data phase completing in the same cycle will clear or set a slot, the address-phase compare sees the post-update value.
- `s_hrdata` = `m_hrdata`. `s_hresp` = `m_hresp` except during a local data phase. `s_hready` = `m_hready` except during a local data phase (forced 1).
- Two-cycle AHB error responses from downstream pass through unchanged; local fails never signal an error.

## Timing
- Reset values: all `res_vld`=0; data phase idle; `s_hready`=1, `s_hresp`=0, `s_hexokay`=0; `m_htrans`=IDLE (`s_htrans` held IDLE).
- Address path is combinational with zero latency. Reservation updates are registered and take effect at the clock edge ending the data phase.
- `s_hexokay` is combinational from registered data-phase flags. It is valid only while `s_hready`=1 in a data phase and 0 at all other times.
- Wait states: reservation updates occur only on the cycle with `m_hready`=1. Stalled data phases hold all state.
- During a local-fail data phase, the next address phase passes downstream. The downstream slave sees an IDLE data phase and returns ready with zero waits.
- `rst` asserted mid-transfer clears all state immediately; in-flight reservations are lost.

## Test plan
- LR/SC success: hart 0 exclusive read at 0x100, then exclusive write 0x100 data 0xCAFE → both reach `m_htrans`=NSEQ; `s_hexokay`=1 on both; memory[0x100]=0xCAFE; slot 0 is invalid afterwards.
- SC without LR: hart 1 exclusive write 0x200 → `m_htrans`=IDLE; 1-cycle local response with `s_hexokay`=0, `s_hresp`=0; memory unchanged.
- Intervening store: hart 0 LR 0x100; hart 1 plain byte write 0x103; hart 0 SC 0x100 → SC suppressed, `s_hexokay`=0.
- Forwarding: hart 1 plain write 0x100 data phase (with 2 wait states) coincides with hart 0 SC 0x100 address phase, after hart 0 LR 0x100 → SC fails.
- Debugger: `hmaster`=0x10, `hexcl`=1, write 0x100 → passes as plain, `s_hexokay`=0; it also clears hart 0's reservation on 0x100.
- Error on LR: slave returns a two-cycle ERROR on hart 0 LR 0x300 → no reservation set; a subsequent SC to 0x300 fails locally. Asserting `rst` mid-wait-state returns all outputs to their reset values.
